uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART byte transmitter (TX_En_Sig/TX_Data/TX_Done_Sig handshake) among N_REQ requesters.
//  Round-robin arbitration, one byte per grant; latches the winner's byte and holds TX_En_Sig high until done.
//  Returns a one-cycle ACK to the winner.
//  Sits between application sources (loopback echo, status reporter, debug dump) and tx_control_module.
// PARAMETERS
//  N_REQ    4  number of requesters, 2..8
//  ID_W     2  width of grant index, = clog2(N_REQ)
// PORTS
//  CLOCK        in   1          system clock
//  RST_n        in   1          asynchronous, active-low reset
//  REQ          in   N_REQ      per-requester send request; level, held until matching ACK
//  REQ_DATA     in   8*N_REQ    byte for requester k at [8k+7:8k]; sampled on grant edge only
//  ACK          out  N_REQ      one-hot, one-cycle pulse: byte of requester k fully sent
//  TX_En_Sig    out  1          enable to transmitter; high for whole frame
//  TX_Data      out  8          latched byte to transmitter; stable while TX_En_Sig=1
//  TX_Done_Sig  in   1          transmitter done pulse (one CLOCK cycle)
//  BUSY         out  1          1 from grant edge through ACK cycle
//  GRANT_ID     out  ID_W       index of current/last granted requester
// BEHAVIOUR
//  Reset values: ACK=0, TX_En_Sig=0, TX_Data=8'h00, BUSY=0, GRANT_ID=0.
//  Reset: internal last_ptr=N_REQ-1, so requester 0 wins first. FSM resets to IDLE.
//  FSM IDLE:
//   - if |REQ: winner = first k with REQ[k]=1, searching from last_ptr+1 upward, mod N_REQ.
//   - Same edge: TX_Data<=REQ_DATA[winner]; GRANT_ID<=winner; last_ptr<=winner; TX_En_Sig<=1; BUSY<=1.
//   - Next state SEND. Latency from REQ assert (in IDLE) to TX_En_Sig=1: 1 cycle.
//  FSM SEND:
//   - Hold TX_En_Sig=1 and TX_Data; ignore REQ changes.
//   - On cycle TX_Done_Sig=1: next edge TX_En_Sig<=0, ACK[GRANT_ID]<=1; go DONE.
//  FSM DONE (1 cycle): ACK pulse visible, BUSY=1.
//   - Next edge: ACK<=0, BUSY<=0; go IDLE.
//   - Guarantees TX_En_Sig low >=2 cycles between frames; transmitter restarts cleanly at its idle step.
//  Requester rule: on seeing ACK, drop REQ or present next byte on the same edge.
//   - Re-request is serviced after all other pending requesters (round-robin fairness).
//  Boundary cases:
//   - All N_REQ requesting: grants rotate 0,1,..,N_REQ-1,0; each requester waits at most N_REQ-1 frames.
//   - REQ[k] dropped while k granted: frame completes; ACK[k] still pulsed; no abort.
//   - TX_Done_Sig in IDLE or DONE: ignored.
//   - REQ rises in DONE cycle: not seen until IDLE; next grant 1 cycle later.
//   - RST_n mid-frame: immediate return to reset values (TX_En_Sig=0). Transmitter shares RST_n.
//   - GRANT_ID holds last value while idle.
//   - No timeout; the transmitter is guaranteed to finish a frame.
// CONFIGURATION
//  Macro UART_TX_ARB_LOCK_EN:
//   - Defined: adds input LOCK [N_REQ-1:0].
//   - In DONE, if LOCK[GRANT_ID]=1 and REQ[GRANT_ID]=1: skip arbitration; re-grant same requester.
//   - Re-grant path: latch its REQ_DATA on the DONE->SEND edge; BUSY stays 1; no IDLE cycle.
//   - Used for multi-byte messages that must not interleave.
//   - LOCK of a non-granted requester has no effect.
//   - Not defined: no LOCK port; pure round-robin, one byte per grant.
// TESTING
//  T1 reset: assert RST_n=0 mid-frame.
//     -> TX_En_Sig=0, ACK=0, BUSY=0 at once; after release, REQ=4'b1000 grants 3.
//  T2 single: REQ[2]=1, data 8'hA5.
//     -> next cycle TX_En_Sig=1, TX_Data=A5, GRANT_ID=2.
//     -> on TX_Done_Sig: ACK=4'b0100 for 1 cycle, then BUSY=0.
//  T3 fairness: REQ=4'b1111 held, bytes 10,11,12,13.
//     -> frames sent 10,11,12,13,10; each ACK one-hot in that order.
//  T4 pointer: after grant 1, REQ=4'b0011.
//     -> grant 0 next (search starts at 2, wraps to 0), then 1.
//  T5 drop: REQ[0] deasserted during SEND.
//     -> TX_Data unchanged, frame completes, ACK[0] pulses.
//  T6 LOCK_EN: LOCK[1]=1, REQ=4'b0011, bytes 41,42,43 from requester 1.
//     -> 41,42,43 sent back-to-back before any 0 byte; without macro they interleave.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ requesters.
// Optional macro UART_TX_ARB_LOCK_EN adds a LOCK input for uninterrupted multi-byte messages.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               CLOCK,
  input  logic               RST_n,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] REQ_DATA,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   LOCK,
`endif
  output logic [N_REQ-1:0]   ACK,
  output logic               TX_En_Sig,
  output logic [7:0]         TX_Data,
  input  logic               TX_Done_Sig,
  output logic               BUSY,
  output logic [ID_W-1:0]    GRANT_ID
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_ptr, last_ptr_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [ID_W-1:0]   winner;
  logic              winner_vld;
  logic [7:0]        data_nxt;
  logic              en_nxt;
  logic              busy_nxt;
  logic [N_REQ-1:0]  ack_nxt;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!winner_vld && REQ[wrap_idx(last_ptr, i)]) begin
        winner     = wrap_idx(last_ptr, i);
        winner_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    en_nxt       = TX_En_Sig;
    data_nxt     = TX_Data;
    busy_nxt     = BUSY;
    grant_nxt    = GRANT_ID;
    last_ptr_nxt = last_ptr;
    ack_nxt      = '0;
    case (state)
      IDLE: begin
        if (winner_vld) begin
          data_nxt     = REQ_DATA[8*int'(winner) +: 8];
          grant_nxt    = winner;
          last_ptr_nxt = winner;
          en_nxt       = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = SEND;
        end
      end
      SEND: begin
        if (TX_Done_Sig) begin
          en_nxt            = 1'b0;
          ack_nxt[GRANT_ID] = 1'b1;
          state_nxt         = DONE;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
        // A locked requester keeps the transmitter without going back through arbitration.
        if (LOCK[GRANT_ID] && REQ[GRANT_ID]) begin
          data_nxt  = REQ_DATA[8*int'(GRANT_ID) +: 8];
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SEND;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      last_ptr  <= ID_W'(N_REQ - 1);
      GRANT_ID  <= '0;
      TX_Data   <= 8'h00;
      TX_En_Sig <= 1'b0;
      BUSY      <= 1'b0;
      ACK       <= '0;
    end else begin
      state     <= state_nxt;
      last_ptr  <= last_ptr_nxt;
      GRANT_ID  <= grant_nxt;
      TX_Data   <= data_nxt;
      TX_En_Sig <= en_nxt;
      BUSY      <= busy_nxt;
      ACK       <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester byte lists, a transmitter model,
// and a monitor that checks every frame start and ACK against the expected queue.
module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic               CLOCK = 1'b0;
  logic               RST_n;
  logic [N_REQ-1:0]   REQ;
  logic [8*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]   ACK;
  logic               TX_En_Sig;
  logic [7:0]         TX_Data;
  logic               TX_Done_Sig;
  logic               BUSY;
  logic [ID_W-1:0]    GRANT_ID;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N_REQ-1:0]   LOCK;
`endif

  uart_tx_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .REQ(REQ), .REQ_DATA(REQ_DATA),
`ifdef UART_TX_ARB_LOCK_EN
    .LOCK(LOCK),
`endif
    .ACK(ACK), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data), .TX_Done_Sig(TX_Done_Sig),
    .BUSY(BUSY), .GRANT_ID(GRANT_ID)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      data;
  } frame_t;

  frame_t     sbQueue[$];
  int         checkCount = 0;
  int         errorCount = 0;
  logic [7:0] reqBytes[N_REQ][3];
  int         reqLen[N_REQ];
  int         reqPos[N_REQ];
  int         txCnt;
  logic       spuriousDone;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic refreshReq();
    for (int k = 0; k < N_REQ; k++) begin
      if (reqPos[k] < reqLen[k]) begin
        REQ[k] = 1'b1;
        REQ_DATA[8*k +: 8] = reqBytes[k][reqPos[k]];
      end else begin
        REQ[k] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int k, input int n, input logic [7:0] b0,
                               input logic [7:0] b1, input logic [7:0] b2);
    reqBytes[k][0] = b0;
    reqBytes[k][1] = b1;
    reqBytes[k][2] = b2;
    reqLen[k] = n;
    reqPos[k] = 0;
    refreshReq();
  endtask

  task automatic pushExpected(input int id, input logic [7:0] data);
    frame_t f;
    f.id   = id[ID_W-1:0];
    f.data = data;
    sbQueue.push_back(f);
  endtask

  // One cycle of the world around the DUT: transmitter finishes two cycles after enable,
  // requesters advance to their next byte on the cycle their ACK is visible.
  task automatic tickCycle();
    @(negedge CLOCK);
    if (spuriousDone) TX_Done_Sig = 1'b1;
    else if (TX_En_Sig && !TX_Done_Sig) begin
      txCnt++;
      if (txCnt >= 2) begin
        TX_Done_Sig = 1'b1;
        txCnt = 0;
      end
    end else TX_Done_Sig = 1'b0;
    for (int k = 0; k < N_REQ; k++)
      if (ACK[k]) reqPos[k]++;
    refreshReq();
  endtask

  task automatic waitIdle(input string name);
    bit allDone;
    for (int c = 0; c < 300; c++) begin
      allDone = 1'b1;
      for (int k = 0; k < N_REQ; k++)
        if (reqPos[k] < reqLen[k]) allDone = 1'b0;
      if (sbQueue.size() == 0 && !BUSY && allDone) break;
      tickCycle();
    end
    checkOutput({"drain_", name}, {31'd0, (sbQueue.size() == 0 && !BUSY)}, 32'd1);
  endtask

  task automatic waitAck(input string name);
    for (int c = 0; c < 100; c++) begin
      tickCycle();
      if (ACK != '0) break;
    end
    checkOutput({"ack_seen_", name}, {31'd0, (ACK != '0)}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on each new frame and pairs it with the following ACK.
  initial begin : monitor
    logic   prevTxEn;
    logic   curActive;
    frame_t cur;
    prevTxEn  = 1'b0;
    curActive = 1'b0;
    cur       = '0;
    forever begin
      @(negedge CLOCK);
      if (!RST_n) begin
        prevTxEn  = 1'b0;
        curActive = 1'b0;
      end else begin
        if (TX_En_Sig && !prevTxEn) begin
          if (sbQueue.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpected_frame actual id=%0d data=%0h required none", GRANT_ID, TX_Data);
            curActive = 1'b0;
          end else begin
            cur = sbQueue.pop_front();
            curActive = 1'b1;
            checkOutput("frame_id", 32'(GRANT_ID), 32'(cur.id));
            checkOutput("frame_data", 32'(TX_Data), 32'(cur.data));
            checkOutput("frame_busy", 32'(BUSY), 32'd1);
          end
        end else if (TX_En_Sig && curActive) begin
          checkOutput("data_stable", 32'(TX_Data), 32'(cur.data));
        end
        if (ACK != '0) begin
          if (!curActive) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpected_ack actual=%0h required 0", ACK);
          end else begin
            checkOutput("ack_onehot", 32'(ACK), 32'(1) << cur.id);
            checkOutput("ack_en_low", 32'(TX_En_Sig), 32'd0);
            checkOutput("ack_busy", 32'(BUSY), 32'd1);
            curActive = 1'b0;
          end
        end
        prevTxEn = TX_En_Sig;
      end
    end
  end

  initial begin
    RST_n        = 1'b0;
    REQ          = '0;
    REQ_DATA     = '0;
    TX_Done_Sig  = 1'b0;
    spuriousDone = 1'b0;
    txCnt        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      reqLen[k] = 0;
      reqPos[k] = 0;
    end
`ifdef UART_TX_ARB_LOCK_EN
    LOCK = '0;
`endif
    #12;
    checkOutput("rst_ack", 32'(ACK), 32'd0);
    checkOutput("rst_en", 32'(TX_En_Sig), 32'd0);
    checkOutput("rst_data", 32'(TX_Data), 32'd0);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_grant", 32'(GRANT_ID), 32'd0);
    @(negedge CLOCK);
    RST_n = 1'b1;
    tickCycle();

    // Fairness from reset: requester 0 wins first, then rotation.
    applyStimulus(0, 2, 8'h10, 8'h10, 8'h00);
    applyStimulus(1, 1, 8'h11, 8'h00, 8'h00);
    applyStimulus(2, 1, 8'h12, 8'h00, 8'h00);
    applyStimulus(3, 1, 8'h13, 8'h00, 8'h00);
    pushExpected(0, 8'h10);
    pushExpected(1, 8'h11);
    pushExpected(2, 8'h12);
    pushExpected(3, 8'h13);
    pushExpected(0, 8'h10);
    waitIdle("fairness");

    // Single request, one-cycle grant latency, BUSY drops after the ACK cycle.
    applyStimulus(2, 1, 8'hA5, 8'h00, 8'h00);
    pushExpected(2, 8'hA5);
    tickCycle();
    checkOutput("single_latency_en", 32'(TX_En_Sig), 32'd1);
    checkOutput("single_grant", 32'(GRANT_ID), 32'd2);
    waitAck("single");
    tickCycle();
    checkOutput("single_busy_after", 32'(BUSY), 32'd0);
    checkOutput("single_en_after", 32'(TX_En_Sig), 32'd0);
    waitIdle("single");

    // Pointer after grant 1: search wraps to 0 before 1.
    applyStimulus(1, 1, 8'h21, 8'h00, 8'h00);
    pushExpected(1, 8'h21);
    waitIdle("ptr_a");
    applyStimulus(0, 1, 8'h30, 8'h00, 8'h00);
    applyStimulus(1, 1, 8'h31, 8'h00, 8'h00);
    pushExpected(0, 8'h30);
    pushExpected(1, 8'h31);
    waitIdle("ptr_b");

    // Request dropped mid-frame with garbage data: frame and ACK still complete.
    applyStimulus(0, 1, 8'h50, 8'h00, 8'h00);
    pushExpected(0, 8'h50);
    tickCycle();
    reqLen[0] = 0;
    REQ[0] = 1'b0;
    REQ_DATA[7:0] = 8'hFF;
    waitIdle("drop");

    // Done pulses while idle must not start anything; GRANT_ID holds.
    spuriousDone = 1'b1;
    repeat (3) tickCycle();
    checkOutput("spur_busy", 32'(BUSY), 32'd0);
    checkOutput("spur_en", 32'(TX_En_Sig), 32'd0);
    checkOutput("spur_ack", 32'(ACK), 32'd0);
    checkOutput("spur_grant_hold", 32'(GRANT_ID), 32'd0);
    spuriousDone = 1'b0;
    tickCycle();

    // Request raised during the DONE cycle is granted one IDLE cycle later.
    applyStimulus(2, 1, 8'h60, 8'h00, 8'h00);
    pushExpected(2, 8'h60);
    pushExpected(3, 8'h70);
    waitAck("late_req");
    applyStimulus(3, 1, 8'h70, 8'h00, 8'h00);
    tickCycle();
    checkOutput("late_idle_en", 32'(TX_En_Sig), 32'd0);
    checkOutput("late_idle_busy", 32'(BUSY), 32'd0);
    tickCycle();
    checkOutput("late_grant_en", 32'(TX_En_Sig), 32'd1);
    checkOutput("late_grant_id", 32'(GRANT_ID), 32'd3);
    waitIdle("late_req");

    // Park the pointer on 0 so requester 1 wins the multi-byte test first.
    applyStimulus(0, 1, 8'h3F, 8'h00, 8'h00);
    pushExpected(0, 8'h3F);
    waitIdle("park");

`ifdef UART_TX_ARB_LOCK_EN
    LOCK = 4'b0010;
`endif
    applyStimulus(0, 1, 8'h40, 8'h00, 8'h00);
    applyStimulus(1, 3, 8'h41, 8'h42, 8'h43);
    pushExpected(1, 8'h41);
`ifdef UART_TX_ARB_LOCK_EN
    pushExpected(1, 8'h42);
    pushExpected(1, 8'h43);
    pushExpected(0, 8'h40);
`else
    pushExpected(0, 8'h40);
    pushExpected(1, 8'h42);
    pushExpected(1, 8'h43);
`endif
    waitIdle("multibyte");
`ifdef UART_TX_ARB_LOCK_EN
    LOCK = '0;
`endif

    // Reset mid-frame returns outputs to reset values immediately.
    applyStimulus(1, 1, 8'h77, 8'h00, 8'h00);
    pushExpected(1, 8'h77);
    tickCycle();
    tickCycle();
    checkOutput("pre_rst_en", 32'(TX_En_Sig), 32'd1);
    RST_n = 1'b0;
    #1;
    checkOutput("midrst_en", 32'(TX_En_Sig), 32'd0);
    checkOutput("midrst_ack", 32'(ACK), 32'd0);
    checkOutput("midrst_busy", 32'(BUSY), 32'd0);
    checkOutput("midrst_data", 32'(TX_Data), 32'd0);
    checkOutput("midrst_grant", 32'(GRANT_ID), 32'd0);
    for (int k = 0; k < N_REQ; k++) begin
      reqLen[k] = 0;
      reqPos[k] = 0;
    end
    REQ = '0;
    TX_Done_Sig = 1'b0;
    txCnt = 0;
    tickCycle();
    RST_n = 1'b1;
    applyStimulus(3, 1, 8'h88, 8'h00, 8'h00);
    pushExpected(3, 8'h88);
    waitIdle("after_rst");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
